// File: rtl/midi_vel_router.sv
// midi_vel_router
//   Turns a MIDI velocity into a number of enabled stepper channels and gates
//   the FM step clock onto them. Enable changes are applied only while FM_in
//   is low, so a step pulse is never cut short. If FM_in stays high too long,
//   the change is forced through after HOLD_MAX edges.
//
//   Optional feature: define MIDI_VEL_ROTATE_EN to rotate the first enabled
//   channel each time the router wakes up from zero active channels. Without
//   it, channels 0..K-1 are used.
//
// Ports
//   Clk         in   system clock, rising edge
//   Reset       in   synchronous active-high reset
//   velocity    in   [7:0] 0 = off, 1..127 = volume, 128..255 = invalid
//   FM_in       in   step clock from the FM generator
//   Ch          out  [NUM_CH-1:0] FM_in gated by the registered channel enables
//   ActiveCount out  [3:0] number of channels enabled
//   Invalid     out  velocity[7] as sampled on the previous edge
//   Forced      out  one-cycle pulse after an update applied by timeout
module midi_vel_router #(
  parameter int NUM_CH   = 4,
  parameter int HOLD_MAX = 1024
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        velocity,
  input  logic              FM_in,
  output logic [NUM_CH-1:0] Ch,
  output logic [3:0]        ActiveCount,
  output logic              Invalid,
  output logic              Forced
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

  logic [3:0]        active_q, active_d;
  logic [2:0]        base_q, base_d;
  logic [15:0]       hold_q, hold_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic              invalid_q, invalid_d;
  logic              forced_q, forced_d;

  logic [10:0] prod;
  logic [3:0]  k_val;
  logic        apply;
  logic [3:0]  rel;

  // Full product width is kept; 127 * 8 still fits in 11 bits.
  assign prod  = 11'(velocity[6:0]) * 11'(NUM_CH);
  assign k_val = (velocity == 8'd0) ? 4'd0 : 4'(prod >> 7) + 4'd1;

  always_comb begin
    active_d  = active_q;
    base_d    = base_q;
    hold_d    = hold_q;
    en_d      = en_q;
    invalid_d = velocity[7];
    forced_d  = 1'b0;
    apply     = 1'b0;
    rel       = 4'd0;

    // Invalid velocity freezes everything except the Invalid flag.
    if (!velocity[7]) begin
      if (k_val == active_q) begin
        hold_d = 16'd0;
      end else if (!FM_in) begin
        apply = 1'b1;
      end else if (hold_q >= HOLD_LAST) begin
        apply    = 1'b1;
        forced_d = 1'b1;
      end else begin
        hold_d = hold_q + 16'd1;
      end

      if (apply) begin
        hold_d   = 16'd0;
        active_d = k_val;
`ifdef MIDI_VEL_ROTATE_EN
        // Waking from zero: k_val is nonzero here since it differs from 0.
        if (active_q == 4'd0) begin
          base_d = (base_q == 3'(NUM_CH - 1)) ? 3'd0 : base_q + 3'd1;
        end
`endif
        // Channel i is on when its distance past base is below the count.
        for (int i = 0; i < NUM_CH; i++) begin
          if (4'(i) >= {1'b0, base_d}) rel = 4'(i) - {1'b0, base_d};
          else                         rel = 4'(i + NUM_CH) - {1'b0, base_d};
          en_d[i] = (rel < active_d);
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      active_q  <= 4'd0;
      base_q    <= 3'd0;
      hold_q    <= 16'd0;
      en_q      <= '0;
      invalid_q <= 1'b0;
      forced_q  <= 1'b0;
    end else begin
      active_q  <= active_d;
      base_q    <= base_d;
      hold_q    <= hold_d;
      en_q      <= en_d;
      invalid_q <= invalid_d;
      forced_q  <= forced_d;
    end
  end

  assign Ch          = {NUM_CH{FM_in}} & en_q;
  assign ActiveCount = active_q;
  assign Invalid     = invalid_q;
  assign Forced      = forced_q;

endmodule

// File: tb/tb_midi_vel_router.sv
module tb_midi_vel_router;
  localparam int NUM_CH   = 4;
  localparam int HOLD_MAX = 8;
`ifdef MIDI_VEL_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic              Clk;
  logic              Reset;
  logic [7:0]        velocity;
  logic              FM_in;
  logic [NUM_CH-1:0] Ch;
  logic [3:0]        ActiveCount;
  logic              Invalid;
  logic              Forced;

  midi_vel_router #(.NUM_CH(NUM_CH), .HOLD_MAX(HOLD_MAX)) dut (
    .Clk(Clk), .Reset(Reset), .velocity(velocity), .FM_in(FM_in),
    .Ch(Ch), .ActiveCount(ActiveCount), .Invalid(Invalid), .Forced(Forced)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int m_cnt = 0, m_base = 0, m_hold = 0, m_inv = 0, m_forced = 0;

  function automatic int target(input logic [7:0] v);
    if (v == 8'd0) return 0;
    return (int'(v[6:0]) * NUM_CH) / 128 + 1;
  endfunction

  function automatic logic [NUM_CH-1:0] mask();
    logic [NUM_CH-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_CH; i++)
      m[i] = (((i - m_base + NUM_CH) % NUM_CH) < m_cnt);
    return m;
  endfunction

  task automatic model(input logic [7:0] v, input logic fm, input logic rst);
    int k;
    if (rst) begin
      m_cnt = 0; m_base = 0; m_hold = 0; m_inv = 0; m_forced = 0;
      return;
    end
    m_inv    = v[7];
    m_forced = 0;
    if (v[7]) return;
    k = target(v);
    if (k == m_cnt) begin
      m_hold = 0;
    end else if (!fm || m_hold == HOLD_MAX - 1) begin
      m_forced = fm;
      if (ROT && m_cnt == 0) m_base = (m_base + 1) % NUM_CH;
      m_cnt  = k;
      m_hold = 0;
    end else begin
      m_hold = m_hold + 1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic [7:0] v, input logic fm, input logic rst, input string tag);
    @(negedge Clk);
    velocity = v; FM_in = fm; Reset = rst;
    @(posedge Clk);
    model(v, fm, rst);
    #1;
    check({tag, ":cnt"},    16'(ActiveCount), 16'(m_cnt));
    check({tag, ":inv"},    16'(Invalid),     16'(m_inv));
    check({tag, ":forced"}, 16'(Forced),      16'(m_forced));
    check({tag, ":ch"},     16'(Ch),          16'(fm ? mask() : '0));
  endtask

  // Ch is a combinational gate: flip FM_in between edges and recheck.
  task automatic flip_check(input string tag);
    #2 FM_in = ~FM_in;
    #1 check({tag, ":chflip"}, 16'(Ch), 16'(FM_in ? mask() : '0));
  endtask

  logic [7:0] v;
  logic       fm, rst;

  initial begin
    Reset = 1'b1; velocity = 8'd0; FM_in = 1'b0;
    step(8'd0, 1'b1, 1'b1, "reset");
    check("reset_cnt0", 16'(ActiveCount), 16'd0);

    // 0 -> 40 with FM low: two channels, rotated to base 1 when enabled
    step(8'd40, 1'b0, 1'b0, "v40");
    check("v40_cnt", 16'(ActiveCount), 16'd2);
    step(8'd40, 1'b1, 1'b0, "v40_fm");
    check("v40_ch", 16'(Ch), ROT ? 16'h6 : 16'h3);
    flip_check("v40");

    // 40 -> 0 -> 100
    step(8'd0,   1'b0, 1'b0, "v0");
    step(8'd100, 1'b0, 1'b0, "v100");
    step(8'd100, 1'b1, 1'b0, "v100_fm");
    check("v100_ch", 16'(Ch), 16'hF);

    // K boundaries
    step(8'd31, 1'b0, 1'b0, "k31");  check("k31", 16'(ActiveCount), 16'd1);
    step(8'd32, 1'b0, 1'b0, "k32");  check("k32", 16'(ActiveCount), 16'd2);
    step(8'd95, 1'b0, 1'b0, "k95");  check("k95", 16'(ActiveCount), 16'd3);
    step(8'd96, 1'b0, 1'b0, "k96");  check("k96", 16'(ActiveCount), 16'd4);
    step(8'd127, 1'b0, 1'b0, "k127"); check("k127", 16'(ActiveCount), 16'd4);

    // Hold with FM stuck high: 20 -> 70 forced on 8th edge
    step(8'd20, 1'b0, 1'b0, "h20");
    for (int i = 0; i < 7; i++) step(8'd70, 1'b1, 1'b0, "hold");
    check("hold_cnt", 16'(ActiveCount), 16'd1);
    step(8'd70, 1'b1, 1'b0, "hold8");
    check("hold8_forced", 16'(Forced), 16'd1);
    check("hold8_cnt", 16'(ActiveCount), 16'd3);
    step(8'd70, 1'b1, 1'b0, "hold9");
    check("hold9_forced", 16'(Forced), 16'd0);

    // Pending then cancel, then applied on FM fall
    step(8'd40, 1'b1, 1'b0, "cancel_a");
    step(8'd70, 1'b1, 1'b0, "cancel_b");
    step(8'd40, 1'b1, 1'b0, "pend");
    step(8'd40, 1'b0, 1'b0, "pend_apply");
    check("pend_apply", 16'(ActiveCount), 16'd2);

    // Invalid velocity freezes state
    step(8'd200, 1'b0, 1'b0, "inv");
    check("inv_flag", 16'(Invalid), 16'd1);
    check("inv_cnt", 16'(ActiveCount), 16'd2);
    step(8'd40, 1'b0, 1'b0, "inv_clr");

    // Reset during pending update, then fresh evaluation
    step(8'd127, 1'b1, 1'b0, "rp_pend");
    step(8'd127, 1'b1, 1'b1, "rp_reset");
    check("rp_reset_cnt", 16'(ActiveCount), 16'd0);
    step(8'd127, 1'b0, 1'b0, "rp_after");
    check("rp_after_cnt", 16'(ActiveCount), 16'd4);

    // 0 -> 1 three times
    for (int i = 0; i < 3; i++) begin
      step(8'd0, 1'b0, 1'b0, "wake0");
      step(8'd1, 1'b1, 1'b1 & 1'b0, "wake1_pend");
      step(8'd1, 1'b0, 1'b0, "wake1");
      step(8'd1, 1'b1, 1'b0, "wake1_fm");
    end

    // Randomized run
    v = 8'd0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 40) begin
        case ($urandom_range(0, 9))
          0:       v = 8'($urandom_range(128, 255));
          1, 2:    v = 8'd0;
          default: v = 8'($urandom_range(1, 127));
        endcase
      end
      fm  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) == 0);
      step(v, fm, rst, "rand");
      if ((n % 16) == 0) flip_check("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/midi_vel_router.md
MIDI_VEL_ROUTER -- requirements
Module: midi_vel_router

Interface
REQ-001 Parameter NUM_CH, default 4, number of stepper channels driven (legal 1..8).
REQ-002 Parameter HOLD_MAX, default 1024, maximum cycles a pending enable update waits for FM_in low before forced apply (legal 1..65535).
REQ-003 Clk  input  1  system clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 velocity  input  8  MIDI velocity; 0 = note off, 1..127 = volume, 128..255 = invalid.
REQ-006 FM_in  input  1  step clock from the FM generator.
REQ-007 Ch  output  NUM_CH  per-channel step outputs, Ch[i] = FM_in AND en[i] (combinational gate, registered enable).
REQ-008 ActiveCount  output  4  number of channels currently enabled (registered).
REQ-009 Invalid  output  1  registered flag: velocity[7] sampled high on the previous edge.
REQ-010 Forced  output  1  one-cycle pulse: an update was applied by HOLD_MAX timeout.

Function
REQ-011 Target count K SHALL be 0 for velocity 0, else ((velocity[6:0] * NUM_CH) >> 7) + 1, computed at full product width, no truncation before the shift.
REQ-012 For NUM_CH=4, K SHALL be 1 for 1..31, 2 for 32..63, 3 for 64..95, 4 for 96..127.
REQ-013 When velocity[7]=1, K SHALL be ignored: en, ActiveCount, base and the hold counter SHALL keep their values.
REQ-014 An update is pending when K differs from ActiveCount (valid velocity only).
REQ-015 A pending update SHALL be applied on a rising edge where FM_in=0; en and ActiveCount change at that edge, Ch reflects it immediately after; no Ch pulse is ever truncated.
REQ-016 Hold counter SHALL count edges with update pending and FM_in=1, clear when no update pending or on apply; on reaching HOLD_MAX-1 the update SHALL be applied on the next edge regardless of FM_in, and Forced pulses high for that one cycle.
REQ-017 Rotation base (0..NUM_CH-1) SHALL advance by 1, wrapping NUM_CH-1 -> 0, on an apply where ActiveCount goes from 0 to nonzero; the new base is used in that same apply.
REQ-018 en[i] SHALL be 1 iff ((i - base) mod NUM_CH) < ActiveCount; count changes without a 0 -> nonzero transition SHALL keep base.
REQ-019 A velocity change back to the current ActiveCount before apply SHALL cancel the pending update with no output change.
REQ-020 Invalid SHALL update every edge independent of pending state.

Reset
REQ-021 Reset SHALL win over all other events in the same cycle.
REQ-022 On Reset: en=0 (Ch all 0), ActiveCount=0, base=0, hold counter=0, Invalid=0, Forced=0.
REQ-023 Reset asserted mid-pending-update SHALL discard the update; after release the current velocity is evaluated fresh.

Configuration
REQ-024 Macro MIDI_VEL_ROTATE_EN: when defined, rotation per REQ-017 is compiled in.
REQ-025 When MIDI_VEL_ROTATE_EN is not defined, base SHALL be constant 0 and channels 0..K-1 are enabled.

Verification
REQ-026 NUM_CH=4, ROTATE on, FM_in=0, velocity 0->40 -> next edge ActiveCount=2, base=1, Ch[2:1] follow FM_in, Ch[0],Ch[3]=0.
REQ-027 velocity 40->0, then 0->100 with FM_in=0 -> ActiveCount 0 then 4, base=2, all four Ch follow FM_in.
REQ-028 FM_in held 1, velocity 20->70 -> Ch unchanged until FM_in falls; with HOLD_MAX=8 and FM_in stuck 1, apply on 8th edge, Forced pulses once, ActiveCount=3.
REQ-029 velocity=200 while ActiveCount=2 -> Invalid=1 next edge, ActiveCount, Ch, base unchanged.
REQ-030 Reset asserted with pending update and velocity=127 -> all outputs 0 at that edge; after release with FM_in=0, ActiveCount=4, base=1.
REQ-031 Macro undefined, velocity 0->1 three times -> Ch[0] only enabled every time, base stays 0.
